// File: rtl/cdb_arbiter_pkg.sv
// Shared types and constants for the common-data-bus arbiter.
//   ARB_RR / ARB_FIXED : arbitration mode selectors for cdb_arbiter.ARB_MODE
//   N_CDB_LANES        : default lane count used by the datapath
//   cdb_lane_t         : one broadcast lane {valid, tag, data} at default widths
//   wrap_inc           : modulo-n increment, safe for non-power-of-two n
package cdb_arbiter_pkg;

  localparam int ARB_RR      = 0;
  localparam int ARB_FIXED   = 1;
  localparam int N_CDB_LANES = 1;

  localparam int CDB_TAG_W  = 3;
  localparam int CDB_DATA_W = 16;

  typedef struct packed {
    logic                  valid;
    logic [CDB_TAG_W-1:0]  tag;
    logic [CDB_DATA_W-1:0] data;
  } cdb_lane_t;

  function automatic int unsigned wrap_inc(int unsigned v, int unsigned n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_rr_picker.sv
// Combinational multi-winner picker.
// Scans req starting at index start (wrapping modulo N_SRC) and grants the
// first N_LANES set bits; the k-th winner is reported on lane k.
//   req        : request vector (occupied holds)
//   start      : first index to scan
//   grant      : one bit per granted source
//   lane_valid : lane k has a winner
//   lane_idx   : source index of lane k's winner
//   last_idx   : index of the final winner in scan order
module cdb_arbiter_rr_picker #(
  parameter  int N_SRC   = 4,
  parameter  int N_LANES = 1,
  localparam int SRC_W   = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0]              req,
  input  logic [SRC_W-1:0]              start,
  output logic [N_SRC-1:0]              grant,
  output logic [N_LANES-1:0]            lane_valid,
  output logic [N_LANES-1:0][SRC_W-1:0] lane_idx,
  output logic [SRC_W-1:0]              last_idx
);

  int unsigned idx;
  int unsigned n_won;

  always_comb begin
    grant      = '0;
    lane_valid = '0;
    lane_idx   = '0;
    last_idx   = '0;
    idx        = 0;
    n_won      = 0;
    for (int unsigned k = 0; k < N_SRC; k++) begin
      idx = (32'(start) + k) % N_SRC;
      if (req[idx] && n_won < N_LANES) begin
        grant[idx]        = 1'b1;
        lane_valid[n_won] = 1'b1;
        lane_idx[n_won]   = idx[SRC_W-1:0];
        last_idx          = idx[SRC_W-1:0];
        n_won             = n_won + 1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter and broadcast stage.
// Each producer owns one hold entry; occupied holds are granted onto
// N_LANES registered CDB lanes, round-robin or fixed priority.
//   clk, rst_n          : clock, async active-low reset
//   flush               : synchronous squash of holds and lanes
//   src_valid/tag/data  : producer results (tag/data flattened per source)
//   src_ready           : producer i accepted on this edge
//   cdb_valid/tag/data  : registered broadcast lanes
//   cdb_src             : source index carried by each lane
//   pending             : number of occupied holds
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int N_SRC    = 4,
  parameter int N_LANES  = N_CDB_LANES,
  parameter int TAG_W    = 3,
  parameter int DATA_W   = 16,
  parameter int ARB_MODE = ARB_RR
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               flush,
  input  logic [N_SRC-1:0]                   src_valid,
  input  logic [N_SRC*TAG_W-1:0]             src_tag,
  input  logic [N_SRC*DATA_W-1:0]            src_data,
  output logic [N_SRC-1:0]                   src_ready,
  output logic [N_LANES-1:0]                 cdb_valid,
  output logic [N_LANES*TAG_W-1:0]           cdb_tag,
  output logic [N_LANES*DATA_W-1:0]          cdb_data,
  output logic [N_LANES*$clog2(N_SRC)-1:0]   cdb_src,
  output logic [$clog2(N_SRC+1)-1:0]         pending
);

  localparam int SRC_W = $clog2(N_SRC);
  localparam int CNT_W = $clog2(N_SRC+1);

  logic [N_SRC-1:0]              hold_valid;
  logic [TAG_W-1:0]              hold_tag  [N_SRC];
  logic [DATA_W-1:0]             hold_data [N_SRC];
  logic [SRC_W-1:0]              rr_ptr;
  logic [SRC_W-1:0]              rr_next;
  logic [SRC_W-1:0]              pick_start;
  logic [N_SRC-1:0]              grant;
  logic [N_SRC-1:0]              accept;
  logic [N_LANES-1:0]            lane_valid;
  logic [N_LANES-1:0][SRC_W-1:0] lane_idx;
  logic [SRC_W-1:0]              last_idx;

  // Grants depend only on hold state, never on the current inputs.
  assign pick_start = (ARB_MODE == ARB_FIXED) ? '0 : rr_ptr;

  cdb_arbiter_rr_picker #(
    .N_SRC   (N_SRC),
    .N_LANES (N_LANES)
  ) u_picker (
    .req        (hold_valid),
    .start      (pick_start),
    .grant      (grant),
    .lane_valid (lane_valid),
    .lane_idx   (lane_idx),
    .last_idx   (last_idx)
  );

  // A granted hold is drained this edge, so it can be refilled on the same edge.
  assign src_ready = flush ? '0 : (~hold_valid | grant);
  assign accept    = src_valid & src_ready;
  assign rr_next   = SRC_W'(wrap_inc(32'(last_idx), N_SRC));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid <= '0;
      for (int unsigned i = 0; i < N_SRC; i++) begin
        hold_tag[i]  <= '0;
        hold_data[i] <= '0;
      end
    end else if (flush) begin
      hold_valid <= '0;
    end else begin
      // Reload wins over the grant-clear so back-to-back transfers never drop.
      for (int unsigned i = 0; i < N_SRC; i++) begin
        if (accept[i]) begin
          hold_valid[i] <= 1'b1;
          hold_tag[i]   <= src_tag[i*TAG_W +: TAG_W];
          hold_data[i]  <= src_data[i*DATA_W +: DATA_W];
        end else if (grant[i]) begin
          hold_valid[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cdb_valid <= '0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
      cdb_src   <= '0;
    end else if (flush) begin
      cdb_valid <= '0;
    end else begin
      for (int unsigned k = 0; k < N_LANES; k++) begin
        cdb_valid[k] <= lane_valid[k];
        if (lane_valid[k]) begin
          cdb_tag[k*TAG_W +: TAG_W]    <= hold_tag[lane_idx[k]];
          cdb_data[k*DATA_W +: DATA_W] <= hold_data[lane_idx[k]];
          cdb_src[k*SRC_W +: SRC_W]    <= lane_idx[k];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (!flush && ARB_MODE == ARB_RR && |grant) begin
      rr_ptr <= rr_next;
    end
  end

  always_comb begin
    pending = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      pending = pending + CNT_W'(hold_valid[i]);
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: three configurations
//   inst0: N_SRC=4 N_LANES=1 round-robin
//   inst1: N_SRC=4 N_LANES=2 fixed priority
//   inst2: N_SRC=3 N_LANES=2 round-robin (non-power-of-two wrap)
module tb_cdb_arbiter;

  localparam int NI = 3;

  function automatic int ns(int i); return (i == 2) ? 3 : 4; endfunction
  function automatic int nl(int i); return (i == 0) ? 1 : 2; endfunction
  function automatic int am(int i); return (i == 1) ? 1 : 0; endfunction

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]   s_valid [NI];
  logic [23:0]  s_tag   [NI];
  logic [127:0] s_data  [NI];
  logic         fl      [NI];

  logic [3:0]  r0; logic [0:0] cv0; logic [2:0] ct0; logic [15:0] cd0; logic [1:0] cs0; logic [2:0] pd0;
  logic [3:0]  r1; logic [1:0] cv1; logic [5:0] ct1; logic [31:0] cd1; logic [3:0] cs1; logic [2:0] pd1;
  logic [2:0]  r2; logic [1:0] cv2; logic [5:0] ct2; logic [31:0] cd2; logic [3:0] cs2; logic [1:0] pd2;

  cdb_arbiter #(.N_SRC(4), .N_LANES(1), .TAG_W(3), .DATA_W(16), .ARB_MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(fl[0]),
    .src_valid(s_valid[0][3:0]), .src_tag(s_tag[0][11:0]), .src_data(s_data[0][63:0]),
    .src_ready(r0), .cdb_valid(cv0), .cdb_tag(ct0), .cdb_data(cd0), .cdb_src(cs0), .pending(pd0));

  cdb_arbiter #(.N_SRC(4), .N_LANES(2), .TAG_W(3), .DATA_W(16), .ARB_MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(fl[1]),
    .src_valid(s_valid[1][3:0]), .src_tag(s_tag[1][11:0]), .src_data(s_data[1][63:0]),
    .src_ready(r1), .cdb_valid(cv1), .cdb_tag(ct1), .cdb_data(cd1), .cdb_src(cs1), .pending(pd1));

  cdb_arbiter #(.N_SRC(3), .N_LANES(2), .TAG_W(3), .DATA_W(16), .ARB_MODE(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .flush(fl[2]),
    .src_valid(s_valid[2][2:0]), .src_tag(s_tag[2][8:0]), .src_data(s_data[2][47:0]),
    .src_ready(r2), .cdb_valid(cv2), .cdb_tag(ct2), .cdb_data(cd2), .cdb_src(cs2), .pending(pd2));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst%0d: got %0h expected %0h at %0t", nm, i, act, exp, $time);
    end
  endtask

  // Reference model: per-source hold slot, lane contents, scan pointer.
  bit        hv  [NI][8];
  bit [2:0]  ht  [NI][8];
  bit [15:0] hd  [NI][8];
  bit        acc [NI][8];
  int        rr  [NI];
  bit        mcv [NI][2];
  bit [2:0]  mct [NI][2];
  bit [15:0] mcd [NI][2];
  int        mcs [NI][2];

  // Winner list in scan order: {count, second winner, first winner}.
  function automatic logic [11:0] pick(int i);
    int st, n, s;
    logic [3:0] w0, w1;
    st = (am(i) == 0) ? rr[i] : 0;
    n = 0; w0 = '0; w1 = '0;
    for (int k = 0; k < ns(i); k++) begin
      s = (st + k) % ns(i);
      if (hv[i][s] && n < nl(i)) begin
        if (n == 0) w0 = 4'(s); else w1 = 4'(s);
        n++;
      end
    end
    return {4'(n), w1, w0};
  endfunction

  function automatic logic [7:0] gmask(logic [11:0] p);
    logic [7:0] m;
    m = '0;
    if (p[11:8] >= 4'd1) m[p[2:0]] = 1'b1;
    if (p[11:8] >= 4'd2) m[p[6:4]] = 1'b1;
    return m;
  endfunction

  logic [11:0] mp;
  logic [7:0]  mg;
  int          mn, mw;

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < NI; i++) begin
      if (!rst_n) begin
        rr[i] = 0;
        for (int s = 0; s < 8; s++) begin hv[i][s] = 0; ht[i][s] = 0; hd[i][s] = 0; acc[i][s] = 0; end
        for (int k = 0; k < 2; k++) begin mcv[i][k] = 0; mct[i][k] = 0; mcd[i][k] = 0; mcs[i][k] = 0; end
      end else begin
        mp = pick(i);
        mg = gmask(mp);
        mn = int'(mp[11:8]);
        for (int s = 0; s < ns(i); s++)
          acc[i][s] = s_valid[i][s] && !fl[i] && (!hv[i][s] || mg[s]);
        if (fl[i]) begin
          for (int s = 0; s < 8; s++) hv[i][s] = 0;
          for (int k = 0; k < 2; k++) mcv[i][k] = 0;
        end else begin
          for (int k = 0; k < nl(i); k++) begin
            if (k < mn) begin
              mw = (k == 0) ? int'(mp[3:0]) : int'(mp[7:4]);
              mcv[i][k] = 1; mct[i][k] = ht[i][mw]; mcd[i][k] = hd[i][mw]; mcs[i][k] = mw;
            end else begin
              mcv[i][k] = 0;
            end
          end
          if (am(i) == 0 && mn > 0)
            rr[i] = (((mn == 1) ? int'(mp[3:0]) : int'(mp[7:4])) + 1) % ns(i);
          for (int s = 0; s < ns(i); s++) begin
            if (acc[i][s]) begin
              hv[i][s] = 1; ht[i][s] = s_tag[i][s*3 +: 3]; hd[i][s] = s_data[i][s*16 +: 16];
            end else if (mg[s]) begin
              hv[i][s] = 0;
            end
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  logic [7:0]  a_r, e_r;
  logic [1:0]  a_cv;
  logic [5:0]  a_ct;
  logic [31:0] a_cd;
  logic [3:0]  a_cs;
  logic [3:0]  a_pd;
  logic [7:0]  cg;
  int          e_pd;

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      case (i)
        0: begin a_r = 8'(r0); a_cv = 2'(cv0); a_ct = 6'(ct0); a_cd = 32'(cd0); a_cs = 4'(cs0); a_pd = 4'(pd0); end
        1: begin a_r = 8'(r1); a_cv = cv1; a_ct = ct1; a_cd = cd1; a_cs = cs1; a_pd = 4'(pd1); end
        default: begin a_r = 8'(r2); a_cv = cv2; a_ct = ct2; a_cd = cd2; a_cs = cs2; a_pd = 4'(pd2); end
      endcase
      cg = gmask(pick(i));
      e_r = '0;
      e_pd = 0;
      for (int s = 0; s < ns(i); s++) begin
        if (!fl[i]) e_r[s] = !hv[i][s] || cg[s];
        if (hv[i][s]) e_pd++;
      end
      chk("src_ready", i, 32'(a_r), 32'(e_r));
      chk("pending", i, 32'(a_pd), 32'(e_pd));
      for (int k = 0; k < nl(i); k++) begin
        chk("cdb_valid", i, 32'(a_cv[k]), 32'(mcv[i][k]));
        chk("cdb_tag", i, 32'(a_ct[k*3 +: 3]), 32'(mct[i][k]));
        chk("cdb_data", i, 32'(a_cd[k*16 +: 16]), 32'(mcd[i][k]));
        chk("cdb_src", i, 32'(a_cs[k*2 +: 2]), 32'(mcs[i][k]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_src(input int i, input int s, input bit v, input logic [2:0] t, input logic [15:0] d);
    s_valid[i][s] = v;
    s_tag[i][s*3 +: 3] = t;
    s_data[i][s*16 +: 16] = d;
  endtask

  task automatic clr_all();
    for (int i = 0; i < NI; i++) begin
      s_valid[i] = '0;
      fl[i] = 1'b0;
    end
  endtask

  task automatic do_reset();
    clr_all();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic rand_drive(input int pct);
    for (int i = 0; i < NI; i++) begin
      fl[i] = ($urandom_range(0, 39) == 0);
      for (int s = 0; s < ns(i); s++) begin
        if (!(s_valid[i][s] && !acc[i][s])) begin
          s_valid[i][s] = ($urandom_range(0, 99) < pct);
          s_tag[i][s*3 +: 3] = 3'($urandom);
          s_data[i][s*16 +: 16] = 16'($urandom);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      s_tag[i] = '0;
      s_data[i] = '0;
    end
    clr_all();

    // Reset state
    tick();
    chk("rst_ready", 0, 32'(r0), 32'h0000000f);
    chk("rst_ready", 1, 32'(r1), 32'h0000000f);
    chk("rst_ready", 2, 32'(r2), 32'h00000007);
    chk("rst_valid", 0, 32'(cv0), 32'h0);
    chk("rst_tag", 0, 32'(ct0), 32'h0);
    chk("rst_data", 0, 32'(cd0), 32'h0);
    chk("rst_src", 0, 32'(cs0), 32'h0);
    chk("rst_pending", 0, 32'(pd0), 32'h0);
    tick();
    rst_n = 1'b1;

    // Single accept, two-edge latency
    set_src(0, 2, 1'b1, 3'd5, 16'h1234);
    tick();
    s_valid[0][2] = 1'b0;
    #1;
    chk("t1_pending_held", 0, 32'(pd0), 32'd1);
    chk("t1_not_yet", 0, 32'(cv0), 32'd0);
    tick();
    #1;
    chk("t1_valid", 0, 32'(cv0), 32'd1);
    chk("t1_tag", 0, 32'(ct0), 32'd5);
    chk("t1_data", 0, 32'(cd0), 32'h1234);
    chk("t1_src", 0, 32'(cs0), 32'd2);
    chk("t1_pending", 0, 32'(pd0), 32'd0);

    // Round-robin fairness with continuous refill
    do_reset();
    for (int s = 0; s < 4; s++) set_src(0, s, 1'b1, 3'(s), 16'(16'h0100 + s));
    tick();
    #1;
    chk("t2_ready0", 0, 32'(r0), 32'b0001);
    for (int n = 1; n <= 8; n++) begin
      tick();
      #1;
      chk("t2_seq_src", 0, 32'(cs0), 32'((n - 1) % 4));
      chk("t2_seq_valid", 0, 32'(cv0), 32'd1);
      chk("t2_ready", 0, 32'(r0), 32'(1 << (n % 4)));
    end
    clr_all();
    repeat (5) tick();

    // Back-to-back on one source
    set_src(0, 1, 1'b1, 3'd1, 16'h0B01);
    for (int c = 0; c <= 4; c++) begin
      tick();
      if (c < 3) set_src(0, 1, 1'b1, 3'(c + 2), 16'(16'h0B00 + c + 2));
      else s_valid[0][1] = 1'b0;
      #1;
      chk("t4_ready", 0, 32'(r0[1]), 32'd1);
      if (c >= 1) begin
        chk("t4_valid", 0, 32'(cv0), 32'd1);
        chk("t4_tag", 0, 32'(ct0), 32'(c));
      end
    end

    // Flush blocks acceptance, clears state, keeps the scan pointer
    do_reset();
    for (int s = 0; s < 4; s++) set_src(0, s, 1'b1, 3'(s + 4), 16'(16'h0C00 + s));
    tick();
    clr_all();
    tick();
    #1;
    chk("t5_pre_valid", 0, 32'(cv0), 32'd1);
    chk("t5_pre_pending", 0, 32'(pd0), 32'd3);
    fl[0] = 1'b1;
    set_src(0, 0, 1'b1, 3'd6, 16'h0C10);
    #1;
    chk("t5_flush_ready", 0, 32'(r0), 32'd0);
    tick();
    fl[0] = 1'b0;
    #1;
    chk("t5_post_valid", 0, 32'(cv0), 32'd0);
    chk("t5_post_pending", 0, 32'(pd0), 32'd0);
    for (int s = 0; s < 4; s++) set_src(0, s, 1'b1, 3'(s), 16'(16'h0D00 + s));
    tick();
    clr_all();
    tick();
    #1;
    chk("t5_rr_kept", 0, 32'(cs0), 32'd1);
    chk("t5_rr_valid", 0, 32'(cv0), 32'd1);

    // Asynchronous reset between edges
    rst_n = 1'b0;
    #1;
    chk("t6_async_valid", 0, 32'(cv0), 32'd0);
    chk("t6_async_pending", 0, 32'(pd0), 32'd0);
    chk("t6_async_ready", 0, 32'(r0), 32'h0000000f);
    tick();
    rst_n = 1'b1;

    // Fixed priority, two lanes
    for (int s = 0; s < 4; s++) set_src(1, s, 1'b1, 3'(s), 16'(16'h00A0 + s));
    tick();
    clr_all();
    tick();
    #1;
    chk("t3_c1_valid", 1, 32'(cv1), 32'b11);
    chk("t3_c1_tag", 1, 32'(ct1), 32'b001_000);
    chk("t3_c1_src", 1, 32'(cs1), 32'b01_00);
    chk("t3_c1_data", 1, cd1, 32'h00A1_00A0);
    tick();
    #1;
    chk("t3_c2_tag", 1, 32'(ct1), 32'b011_010);
    chk("t3_c2_src", 1, 32'(cs1), 32'b11_10);
    tick();
    #1;
    chk("t3_c3_valid", 1, 32'(cv1), 32'b00);

    // Non-power-of-two wrap: last grant 2 -> pointer 0
    set_src(2, 1, 1'b1, 3'd1, 16'h0E01);
    set_src(2, 2, 1'b1, 3'd2, 16'h0E02);
    tick();
    clr_all();
    tick();
    #1;
    chk("wrap_c1_valid", 2, 32'(cv2), 32'b11);
    chk("wrap_c1_src", 2, 32'(cs2), 32'b10_01);
    for (int s = 0; s < 3; s++) set_src(2, s, 1'b1, 3'(s), 16'(16'h0F00 + s));
    tick();
    clr_all();
    tick();
    #1;
    chk("wrap_c2_src", 2, 32'(cs2), 32'b01_00);
    chk("wrap_c2_valid", 2, 32'(cv2), 32'b11);
    tick();
    #1;
    chk("wrap_c3_valid", 2, 32'(cv2), 32'b01);
    chk("wrap_c3_src", 2, 32'(cs2[1:0]), 32'd2);

    // Randomized traffic with occasional flush
    for (int c = 0; c < 1500; c++) begin
      tick();
      rand_drive((c < 500) ? 90 : (c < 1000) ? 40 : 70);
    end
    tick();
    clr_all();
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Parametrised common-data-bus arbiter and broadcast stage for the Tomasulo core.
- Collects results from N_SRC producers (ALU reservation stations, load/store buffer, future multiplier, branch unit) and drives N_LANES registered CDB lanes.
- Lanes are consumed by reservation stations, the ROB and the load/store buffer.
- Generalises the single hard-wired CDB with per-source buffering, valid/ready handshakes, selectable arbitration and multi-lane broadcast.

Parameters:
- N_SRC, 4, number of producer channels (2..8).
- N_LANES, 1, number of CDB lanes broadcast per cycle (1..N_SRC).
- TAG_W, 3, ROB tag width; matches lc3b_rob_addr.
- DATA_W, 16, result width; matches lc3b_word.
- ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous squash from write_results_control.
- src_valid  in  N_SRC  producer i has a result.
- src_tag  in  N_SRC*TAG_W  ROB tag per producer.
- src_data  in  N_SRC*DATA_W  result value per producer.
- src_ready  out  N_SRC  arbiter accepts producer i this cycle.
- cdb_valid  out  N_LANES  lane broadcast valid (registered).
- cdb_tag  out  N_LANES*TAG_W  lane ROB tag (registered).
- cdb_data  out  N_LANES*DATA_W  lane value (registered).
- cdb_src  out  N_LANES*$clog2(N_SRC)  source index of each lane (debug/perf).
- pending  out  $clog2(N_SRC+1)  count of occupied hold registers.

Behaviour:
- Reset is asynchronous and active-low. While rst_n=0:
  - all hold_valid=0, cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_src=0, rr_ptr=0, pending=0.
  - src_ready=1 for every source, because src_ready is combinational from empty holds.
- Per source: one hold entry {valid, tag, data}.
- Handshake:
  - Transfer occurs when src_valid[i] & src_ready[i] at a rising edge.
  - The producer must hold tag/data stable while valid and not ready.
- Grant (combinational, from hold_valid and rr_ptr only; no input-to-grant path):
  - ARB_MODE=0: scan sources in order rr_ptr, rr_ptr+1, … mod N_SRC. The first N_LANES occupied holds get grants. The k-th winner maps to lane k.
  - ARB_MODE=1: same scan, starting at index 0.
- src_ready[i] = ~hold_valid[i] | grant[i] when flush=0, and 0 when flush=1. This gives back-to-back acceptance: a granted entry is replaced on the same edge.
- At each edge (flush=0):
  - Each lane k loads its winner's tag/data/index and sets cdb_valid[k]=1. Lanes with no winner set cdb_valid[k]=0; tag/data hold their old values.
  - Granted holds clear unless simultaneously reloaded.
  - If ARB_MODE=0 and at least one grant occurred, rr_ptr <= (index of last granted source + 1) mod N_SRC. Otherwise rr_ptr is unchanged.
- Latency: a result accepted at edge t appears on the CDB after edge t+1 at the earliest, i.e. 1 cycle of buffering plus a registered lane.
- Throughput: N_LANES results per cycle.
- Starvation bound (ARB_MODE=0): an occupied hold is granted within ceil(N_SRC/N_LANES) cycles.
- Flush (synchronous, sampled at edge):
  - Clears all hold_valid and cdb_valid.
  - No input is accepted that cycle.
  - rr_ptr is unchanged.
  - Takes priority over simultaneous accept and grant.
- pending is combinational: popcount(hold_valid).
- Wrap-around: rr_ptr arithmetic is modulo N_SRC, including non-power-of-two N_SRC (e.g. N_SRC=3: 2→0).
- Reset mid-operation: all in-flight results are dropped immediately, with no partial broadcast.
- Reset deassertion is synchronised externally; the block does not resynchronise it.
- Tags are not checked for uniqueness. Duplicate tags are broadcast as received, and uniqueness is the issue logic's responsibility.

Decomposition:
- lc3b_types additions:
  - parameterised CDB lane struct {valid, tag, data}, or the existing CDB type when TAG_W/DATA_W are default.
  - ARB_RR / ARB_FIXED constants.
  - default N_CDB_LANES constant used by cpu_datapath.
- Sub-module rr_picker:
  - purely combinational.
  - inputs: request vector and start pointer.
  - outputs: up to N_LANES one-hot grants with lane indices.
  - instantiated once; lets the grant logic be verified standalone.
- Hold registers, lane registers, rr_ptr and pending live in cdb_arbiter.

Test Plan:
1. Reset and single accept: N_SRC=4, N_LANES=1, rst_n low → all outputs 0, src_ready=4'b1111. Release reset. Then src_valid=4'b0100, tag=5, data=16'h1234 at edge t → cdb_valid=1, tag=5, data=16'h1234, cdb_src=2 after edge t+1; pending 1→0.
2. Round-robin fairness: holds 0–3 continuously refilled for 8 cycles → cdb_src sequence 0,1,2,3,0,1,2,3; each src_ready high every 4th cycle; no source waits longer than 4 cycles.
3. Fixed priority and two lanes: ARB_MODE=1, N_LANES=2, all four holds full with tags 0–3 → cycle 1 lanes {0,1}, cycle 2 lanes {2,3}; tag order preserved per lane.
4. Back-to-back: source 1 valid every cycle with tags 1,2,3,4, no contention → src_ready stays 1; CDB shows tags 1,2,3,4 on consecutive cycles.
5. Flush: three holds full, flush=1 for one cycle → next cycle cdb_valid=0, pending=0; src_valid asserted during the flush cycle is not accepted (src_ready=0); rr_ptr value preserved.
6. Async reset mid-stream: drop rst_n between edges while cdb_valid=1 → cdb_valid and pending go to 0 immediately without waiting for clk. Non-power-of-two check: N_SRC=3 wraps rr_ptr 2→0.
